// File: rtl/clock_timer_pkg.sv
// clock_timer_pkg: shared types and constants for the clock-cycle timer arbiter
//   timer_state_e            FSM states IDLE, COUNT, DONE
//   CLOCK_TIMER_COUNT_W_DEF  default width of a cycle count
//   CLOCK_TIMER_MAX_REQ      largest supported number of requesters
package clock_timer_pkg;
   typedef enum logic [1:0] {IDLE, COUNT, DONE} timer_state_e;
   localparam int CLOCK_TIMER_COUNT_W_DEF = 16;
   localparam int CLOCK_TIMER_MAX_REQ = 16;
endpackage

// File: rtl/clock_timer_if.sv
// clock_timer_if: request/grant bundle between requesters (master) and the shared timer (slave)
//   req        per-requester request level
//   req_count  packed counts, requester i at [i*COUNT_W +: COUNT_W]
//   abort      cancels the active countdown
//   grant      one-hot timer owner
//   done       one-cycle expiry pulse to the owner
//   busy       timer not idle
//   remaining  current countdown value
interface clock_timer_if
   import clock_timer_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int COUNT_W = CLOCK_TIMER_COUNT_W_DEF
);
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*COUNT_W-1:0] req_count;
   logic                       abort;
   logic [NUM_REQ-1:0]         grant;
   logic [NUM_REQ-1:0]         done;
   logic                       busy;
   logic [COUNT_W-1:0]         remaining;
   modport master (output req, req_count, abort, input grant, done, busy, remaining);
   modport slave (input req, req_count, abort, output grant, done, busy, remaining);
endinterface

// File: rtl/clock_timer_rr_arbiter.sv
// clock_timer_rr_arbiter: combinational one-hot winner selection among requesters
//   clock, reset_n  clock and async active-low reset (pointer only)
//   req             request vector
//   take            the winner is being granted this edge; advances the pointer
//   win             one-hot winner, zero when no request
// CLOCK_TIMER_RR_EN defined: round-robin starting after the last winner;
// undefined: fixed priority, lowest index wins, no pointer register.
module clock_timer_rr_arbiter
   import clock_timer_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               take,
   output logic [NUM_REQ-1:0] win
);
`ifdef CLOCK_TIMER_RR_EN
   localparam int PW = $clog2(NUM_REQ);
   logic [PW-1:0] ptr_q, win_idx, j;
   // Scan from farthest to nearest so the index closest to the pointer wins last.
   always_comb begin
      win = '0;
      win_idx = '0;
      j = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = PW'((int'(ptr_q) + k) % NUM_REQ);
         if (req[j]) begin
            win = NUM_REQ'(1) << j;
            win_idx = j;
         end
      end
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) ptr_q <= '0;
      else if (take && |req) ptr_q <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
`else
   logic unused_ok;
   assign unused_ok = ^{clock, reset_n, take};
   // Isolate the lowest set bit.
   assign win = req & (~req + NUM_REQ'(1));
`endif
endmodule

// File: rtl/clock_timer_arbiter.sv
// clock_timer_arbiter: one countdown timer shared among NUM_REQ requesters
//   clock    single clock, posedge
//   reset_n  async active-low reset
//   bus      clock_timer_if slave: req/req_count/abort in, grant/done/busy/remaining out
// Optional macro CLOCK_TIMER_RR_EN selects round-robin instead of fixed priority.
module clock_timer_arbiter
   import clock_timer_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int COUNT_W = CLOCK_TIMER_COUNT_W_DEF
) (
   input  logic         clock,
   input  logic         reset_n,
   clock_timer_if.slave bus
);
   timer_state_e       state_q, state_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d, win_cnt;
   logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d, win;
   logic               take;
   assign take = (state_q == IDLE) && |bus.req;
   clock_timer_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (bus.req),
      .take    (take),
      .win     (win)
   );
   always_comb begin
      win_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++)
         win_cnt |= win[i] ? bus.req_count[i*COUNT_W +: COUNT_W] : '0;
   end
   // Counter is zeroed whenever COUNT is left so it doubles as the remaining output.
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      grant_d = grant_q;
      done_d = '0;
      if (state_q == IDLE) begin
         if (take) begin
            state_d = COUNT;
            grant_d = win;
            cnt_d = (win_cnt == '0) ? COUNT_W'(1) : win_cnt;
         end
      end else if (state_q == COUNT) begin
         // Cancel is checked before expiry so it wins on the expiry edge.
         if (bus.abort || !(|(bus.req & grant_q))) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d = '0;
         end else if (cnt_q == COUNT_W'(1)) begin
            state_d = DONE;
            grant_d = '0;
            cnt_d = '0;
            done_d = grant_q;
         end else begin
            cnt_d = cnt_q - COUNT_W'(1);
         end
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         grant_q <= '0;
         done_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         grant_q <= grant_d;
         done_q <= done_d;
      end
   assign bus.grant = grant_q;
   assign bus.done = done_q;
   assign bus.busy = (state_q != IDLE);
   assign bus.remaining = cnt_q;
endmodule

// File: tb/tb_clock_timer_arbiter.sv
// tb_clock_timer_arbiter: scoreboard bench; each queue entry holds the outputs expected after one edge and the inputs for the next
module tb_clock_timer_arbiter;
   localparam int NR = 4;
   localparam int CW = 4;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;
   clock_timer_if #(.NUM_REQ(NR), .COUNT_W(CW)) bus ();
   clock_timer_arbiter #(.NUM_REQ(NR), .COUNT_W(CW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );
   typedef struct {
      logic [NR-1:0]    req;
      logic             abort;
      logic [NR*CW-1:0] rc;
      logic [NR-1:0]    grant;
      logic [NR-1:0]    done;
      logic             busy;
      logic [CW-1:0]    rem;
   } exp_t;
   exp_t  exp_q[$];
   int    n_chk = 0;
   int    n_err = 0;
   string tag = "";
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask
   task automatic push(input logic [NR-1:0] req, input logic abort, input logic [NR*CW-1:0] rc,
                       input logic [NR-1:0] grant, input logic [NR-1:0] done, input logic busy,
                       input logic [CW-1:0] rem);
      exp_t e;
      e.req = req;
      e.abort = abort;
      e.rc = rc;
      e.grant = grant;
      e.done = done;
      e.busy = busy;
      e.rem = rem;
      exp_q.push_back(e);
   endtask
   task automatic check_outs(input string t, input logic [NR-1:0] g, input logic [NR-1:0] d,
                             input logic b, input logic [CW-1:0] r);
      check({t, ".grant"}, 32'(bus.grant), 32'(g));
      check({t, ".done"}, 32'(bus.done), 32'(d));
      check({t, ".busy"}, 32'(bus.busy), 32'(b));
      check({t, ".remaining"}, 32'(bus.remaining), 32'(r));
   endtask
   // Pop one entry per edge, compare outputs, then drive the next inputs.
   task automatic run_q();
      int cyc = 0;
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(posedge clock);
         #1;
         check_outs($sformatf("%s@%0d", tag, cyc), e.grant, e.done, e.busy, e.rem);
         bus.req = e.req;
         bus.abort = e.abort;
         bus.req_count = e.rc;
         cyc++;
      end
   endtask
   task automatic start(input int w, input int n);
      bus.req_count = (NR*CW)'($urandom);
      bus.req_count[w*CW +: CW] = CW'(n);
      bus.req = NR'(1) << w;
      bus.abort = 1'b0;
   endtask
   // Expected trace of one service; ck>0 cancels at edge E0+ck (abort or dropped req).
   // req_count is scrambled after the grant to show it is not resampled.
   task automatic push_serve(input int w, input int n, input int ck, input bit by_abort);
      int nn;
      logic [NR-1:0] oh;
      logic [NR*CW-1:0] rnd;
      bit cut;
      nn = (n == 0) ? 1 : n;
      oh = NR'(1) << w;
      for (int k = 0; k <= nn + 1; k++) begin
         rnd = (NR*CW)'($urandom);
         if (ck != 0 && k == ck) begin
            push('0, 1'b0, rnd, '0, '0, 1'b0, '0);
            push('0, 1'b0, rnd, '0, '0, 1'b0, '0);
            push('0, 1'b0, rnd, '0, '0, 1'b0, '0);
            break;
         end
         cut = (ck != 0 && k + 1 == ck);
         if (k < nn) push((cut && !by_abort) ? '0 : oh, cut && by_abort, rnd, oh, '0, 1'b1, CW'(nn - k));
         else if (k == nn) push('0, 1'b0, rnd, '0, oh, 1'b1, '0);
         else push('0, 1'b0, rnd, '0, '0, 1'b0, '0);
      end
   endtask
   initial begin
      logic [NR-1:0] oh;
      int w;
      bus.req = '0;
      bus.abort = 1'b0;
      bus.req_count = '0;
      repeat (2) @(posedge clock);
      #1;
      check_outs("reset", '0, '0, 1'b0, '0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check_outs("idle_after_reset", '0, '0, 1'b0, '0);
      tag = "contention";
      bus.req = '1;
      bus.req_count = {NR{CW'(2)}};
      for (int s = 0; s < 5; s++) begin
`ifdef CLOCK_TIMER_RR_EN
         w = s % NR;
`else
         w = 0;
`endif
         oh = NR'(1) << w;
         push('1, 1'b0, {NR{CW'(2)}}, oh, '0, 1'b1, CW'(2));
         push('1, 1'b0, {NR{CW'(2)}}, oh, '0, 1'b1, CW'(1));
         push((s == 4) ? '0 : '1, 1'b0, {NR{CW'(2)}}, '0, oh, 1'b1, '0);
         push((s == 4) ? '0 : '1, 1'b0, {NR{CW'(2)}}, '0, '0, 1'b0, '0);
      end
      run_q();
      tag = "single";
      start(2, 5);
      push_serve(2, 5, 0, 1'b0);
      run_q();
      tag = "count0";
      start(0, 0);
      push_serve(0, 0, 0, 1'b0);
      run_q();
      tag = "count1";
      start(1, 1);
      push_serve(1, 1, 0, 1'b0);
      run_q();
      tag = "abort";
      start(3, 10);
      push_serve(3, 10, 3, 1'b1);
      run_q();
      tag = "drop";
      start(1, 10);
      push_serve(1, 10, 3, 1'b0);
      run_q();
      tag = "abort_at_expiry";
      start(2, 3);
      push_serve(2, 3, 3, 1'b1);
      run_q();
      tag = "drop_at_expiry";
      start(0, 3);
      push_serve(0, 3, 3, 1'b0);
      run_q();
      tag = "max_count";
      start(3, 15);
      push_serve(3, 15, 0, 1'b0);
      run_q();
      tag = "pre_reset";
      start(1, 10);
      for (int k = 0; k < 4; k++) push(4'b0010, 1'b0, bus.req_count, 4'b0010, '0, 1'b1, CW'(10 - k));
      run_q();
      reset_n = 1'b0;
      bus.req = '0;
      #2;
      check_outs("async_reset", '0, '0, 1'b0, '0);
      @(posedge clock);
      #1;
      check_outs("in_reset", '0, '0, 1'b0, '0);
      bus.req = 4'b1010;
      bus.req_count = {NR{CW'(3)}};
      reset_n = 1'b1;
      tag = "post_reset";
      push(4'b1010, 1'b0, {NR{CW'(3)}}, 4'b0010, '0, 1'b1, CW'(3));
      push(4'b1010, 1'b0, {NR{CW'(3)}}, 4'b0010, '0, 1'b1, CW'(2));
      push(4'b1010, 1'b0, {NR{CW'(3)}}, 4'b0010, '0, 1'b1, CW'(1));
      push('0, 1'b0, {NR{CW'(3)}}, '0, 4'b0010, 1'b1, '0);
      push('0, 1'b0, {NR{CW'(3)}}, '0, '0, 1'b0, '0);
      run_q();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/clock_timer_arbiter.md
# clock_timer_arbiter

Shares one clock-cycle countdown timer among `NUM_REQ` requesters, such as agents, sequences or flush/timeout logic, that need "wait N clocks" services. It sits beside the clock-and-reset generation logic and runs in its clock domain. Each requester raises a request with a cycle count. The block grants one requester at a time, counts the requested cycles, then pulses that requester's `done`.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2–16.
- `COUNT_W`, 16: width of each cycle count.

- `clock`  in  1  single clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level; held until `done` or deliberately dropped.
- `req_count`  in  NUM_REQ*COUNT_W  packed counts; requester i occupies bits [i*COUNT_W +: COUNT_W]; sampled only at grant.
- `abort`  in  1  cancels the active countdown.
- `grant`  out  NUM_REQ  one-hot owner of the timer; all zero when not counting.
- `done`  out  NUM_REQ  one-cycle pulse to the owner when its count expires.
- `busy`  out  1  high in every state except IDLE.
- `remaining`  out  COUNT_W  counter value in COUNT; 0 otherwise.

## Operation
- FSM states: IDLE, COUNT, DONE. Encoding comes from the package enum.
- IDLE:
  - If any `req` is high at a clock edge, select a winner w.
  - Load counter with req_count[w]; a value of 0 is loaded as 1.
  - Set grant = 1<<w and go to COUNT.
- COUNT, at each edge, first matching rule wins:
  - abort=1, or req[w]=0: go to IDLE, clear grant, no `done`.
  - counter==1: go to DONE, clear grant, pulse done[w].
  - Otherwise: decrement counter.
- DONE: unconditionally go to IDLE and clear `done`. No arbitration happens in DONE.
- Winner selection:
  - The rule is set by the Configuration section.
  - The priority pointer is updated on every grant, including grants later aborted or dropped.
- `req` going high in COUNT or DONE is ignored until the next IDLE. `req_count` changes after the grant are ignored.
- Counter width is COUNT_W with no overflow. The maximum count is 2^COUNT_W−1.
- Asynchronous reset:
  - Forces IDLE, counter=0, pointer=0.
  - All outputs (`grant`, `done`, `busy`, `remaining`) go to 0.
  - Any countdown in progress is lost and produces no `done`.

## Timing
- Request seen at edge E0 with count N ≥ 1:
  - `grant`/`busy` high after E0; `remaining`=N.
  - `remaining` reads N−k after edge E0+k.
  - `done` is high for exactly the cycle after edge E0+N, with `grant` already low.
  - IDLE after E0+N+1.
- Count 0 behaves exactly like count 1.
- Back-to-back service: the earliest next grant is at edge E0+N+2, because IDLE always lasts one cycle.
- Cancel: `abort` or a dropped `req` sampled at edge Ea clears `grant` after Ea, with no `done`. This still applies if Ea is the edge on which the counter would have expired: cancel wins.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `CLOCK_TIMER_RR_EN` defined: round-robin arbitration.
  - Search starts at index (last winner + 1) mod NUM_REQ.
  - After reset the search starts at index 0.
- `CLOCK_TIMER_RR_EN` undefined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Package `clock_timer_pkg`:
  - `timer_state_e` enum (IDLE, COUNT, DONE).
  - `CLOCK_TIMER_COUNT_W_DEF` = 16.
  - `CLOCK_TIMER_MAX_REQ` = 16.
- Sub-module `clock_timer_rr_arbiter`:
  - Combinational one-hot selection from `req` and the pointer.
  - Contains the registered pointer when `CLOCK_TIMER_RR_EN` is defined.
  - Reused by any future multi-requester timer.
- Top-level holds the FSM, counter, and output registers.

## Test plan
- Single request: req[2]=1, count=5 at E0 → grant=4'b0100 for 5 cycles; remaining 5,4,3,2,1; done[2] high only in the cycle after E0+5.
- Count 0: req[0]=1, count=0 → `done[0]` one cycle after grant, same as count=1.
- Contention (RR): req=4'b1111 held, all counts=2 → grant order 0,1,2,3,0; 4 cycles per service (grant 2 cycles, DONE, IDLE). With the macro undefined → always requester 0.
- Cancel: count=10, assert `abort` 3 cycles after grant → grant clears next edge, no `done`, `remaining`=0. Repeat with req[w] dropped, then with abort coinciding with the expiry edge → no `done` in either case.
- Reset mid-count: reset_n low while remaining=7 → all outputs 0 immediately, without waiting for a clock edge. After release, req=4'b1010 → grant=4'b0010 (pointer at 0).
- Maximum count: COUNT_W=4, count=15 → exactly 15 grant cycles; no wrap, single `done`.
